// File: rtl/imul_var_lat_param.sv
// Iterative shift-add integer multiplier with val/rdy handshakes, four
// RISC-V style modes (MUL/MULH/MULHU/MULHSU) and zero-run skipping on the multiplier.
module imul_var_lat_param #(
  parameter int unsigned NBITS    = 32,
  parameter int unsigned SKIP_MAX = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [2*NBITS+1:0]   req_msg,
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [NBITS-1:0]     resp_msg
);

  localparam int unsigned SHW = $clog2(SKIP_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [2*NBITS-1:0]     a_q, a_d;
  logic [NBITS-1:0]       b_q, b_d;
  logic [2*NBITS-1:0]     acc_q, acc_d;
  logic                   neg_q, neg_d;
  logic [1:0]             mode_q, mode_d;

  logic [1:0]             req_mode;
  logic [NBITS-1:0]       req_a, req_b;
  logic [NBITS-1:0]       a_mag, b_mag;
  logic                   a_neg, b_neg;

  // Operands are reduced to magnitudes; the sign is reapplied once at the end.
  always_comb begin
    req_mode = req_msg[2*NBITS+1 -: 2];
    req_a    = req_msg[2*NBITS-1 -: NBITS];
    req_b    = req_msg[NBITS-1:0];
    a_neg    = req_mode[0] & req_a[NBITS-1];
    b_neg    = (req_mode == 2'b01) & req_b[NBITS-1];
    a_mag    = a_neg ? -req_a : req_a;
    b_mag    = b_neg ? -req_b : req_b;
  end

  logic [SHW-1:0] k;
  logic           hit;

  // Shift to the next set multiplier bit, capped at SKIP_MAX positions.
  always_comb begin
    k   = SHW'(SKIP_MAX);
    hit = 1'b0;
    for (int unsigned i = 1; i <= SKIP_MAX; i++) begin
      if (!hit && b_q[i]) begin
        k   = SHW'(i);
        hit = 1'b1;
      end
    end
  end

  logic [2*NBITS-1:0] prod;

  always_comb begin
    prod     = neg_q ? -acc_q : acc_q;
    resp_msg = (mode_q == 2'b00) ? prod[NBITS-1:0] : prod[2*NBITS-1:NBITS];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    mode_d   = mode_q;
    req_rdy  = 1'b0;
    resp_val = 1'b0;
    case (state_q)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) begin
          a_d     = (2*NBITS)'(a_mag);
          b_d     = b_mag;
          acc_d   = '0;
          neg_d   = a_neg ^ b_neg;
          mode_d  = req_mode;
          state_d = CALC;
        end
      end
      CALC: begin
        if (b_q == '0) begin
          state_d = DONE;
        end else begin
          if (b_q[0]) acc_d = acc_q + a_q;
          a_d = a_q << k;
          b_d = b_q >> k;
        end
      end
      DONE: begin
        resp_val = 1'b1;
        if (resp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_imul_var_lat_param.sv
// Bench for imul_var_lat_param: directed cases on a 32-bit/skip-8 instance,
// then randomized traffic on three parameter sets against an arithmetic reference.
module tb_imul_var_lat_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rv[3], rr[3], sv[3], sr[3];
  logic [65:0] m0;
  logic [17:0] m1, m2;
  logic [31:0] o0;
  logic [7:0]  o1, o2;

  imul_var_lat_param #(.NBITS(32), .SKIP_MAX(8)) dut0 (
    .clk(clk), .reset(reset), .req_val(rv[0]), .req_rdy(rr[0]), .req_msg(m0),
    .resp_val(sv[0]), .resp_rdy(sr[0]), .resp_msg(o0));
  imul_var_lat_param #(.NBITS(8), .SKIP_MAX(4)) dut1 (
    .clk(clk), .reset(reset), .req_val(rv[1]), .req_rdy(rr[1]), .req_msg(m1),
    .resp_val(sv[1]), .resp_rdy(sr[1]), .resp_msg(o1));
  imul_var_lat_param #(.NBITS(8), .SKIP_MAX(1)) dut2 (
    .clk(clk), .reset(reset), .req_val(rv[2]), .req_rdy(rr[2]), .req_msg(m2),
    .resp_val(sv[2]), .resp_rdy(sr[2]), .resp_msg(o2));

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc;
  int          sel;
  int          nb_of[3] = '{32, 8, 8};
  int          sk_of[3] = '{8, 4, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_msg();
    case (sel)
      0:       return o0;
      1:       return 32'(o1);
      default: return 32'(o2);
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    rv[sel] = v;
    case (sel)
      0:       m0 = {m, a, b};
      1:       m1 = {m, a[7:0], b[7:0]};
      default: m2 = {m, a[7:0], b[7:0]};
    endcase
  endtask

  // Reference: sign-extend per mode, take the full product, pick a half.
  function automatic logic [31:0] ref_mul(int nb, logic [1:0] m, logic [31:0] a, logic [31:0] b);
    longint      mask;
    longint      sa, sb;
    logic [63:0] p;
    mask = (64'sd1 <<< nb) - 1;
    sa   = longint'(a) & mask;
    sb   = longint'(b) & mask;
    if (m[0] && sa[nb-1]) sa = sa - (64'sd1 <<< nb);
    if (m == 2'b01 && sb[nb-1]) sb = sb - (64'sd1 <<< nb);
    p = sa * sb;
    if (m == 2'b00) return 32'(p & mask);
    return 32'((p >> nb) & mask);
  endfunction

  // Number of skip iterations needed to drain |b|.
  function automatic int ref_iters(int nb, int sk, logic [1:0] m, logic [31:0] b);
    longint mag;
    int     n;
    int     j;
    n   = 0;
    mag = longint'(b) & ((64'sd1 <<< nb) - 1);
    if (m == 2'b01 && mag[nb-1]) mag = (64'sd1 <<< nb) - mag;
    while (mag != 0) begin
      j = sk;
      for (int i = sk; i >= 1; i--) if (mag[i]) j = i;
      mag = mag >> j;
      n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] pick(int nb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF >> (32 - nb);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return mask;
      2:       return 32'd1 << (nb - 1);
      3:       return 32'd1;
      default: return $urandom() & mask;
    endcase
  endfunction

  task automatic issue(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (rr[sel] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("req_rdy_wait", 64'(rr[sel]), 64'd1);
    drive(1'b1, m, a, b);
    @(negedge clk);
    acc_cyc = cyc;
    drive(1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic collect(input string tag, input logic [31:0] emsg, input int elat,
                         input int stall, input bit junk);
    int          w;
    logic [31:0] held;
    w = 0;
    while (sv[sel] !== 1'b1 && w < 200) begin
      if (junk) drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom(), $urandom());
      @(negedge clk);
      w++;
    end
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    chk({tag, "_val"}, 64'(sv[sel]), 64'd1);
    chk({tag, "_lat"}, 64'(cyc - acc_cyc + 1), 64'(elat));
    chk({tag, "_msg"}, 64'(out_msg()), 64'(emsg));
    held = out_msg();
    repeat (stall) begin
      @(negedge clk);
      chk({tag, "_stall"}, {sv[sel], rr[sel], out_msg()}, {1'b1, 1'b0, held});
    end
    sr[sel] = 1'b1;
    @(negedge clk);
    sr[sel] = 1'b0;
    chk({tag, "_idle"}, 64'({rr[sel], sv[sel]}), 64'b10);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          ntx;
    logic [1:0]  m;
    logic [31:0] a, b;

    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b0;
      sr[i] = 1'b0;
    end
    m0 = '0; m1 = '0; m2 = '0;
    sel = 0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state0", 64'({rr[0], sv[0], o0}), 64'({1'b1, 1'b0, 32'd0}));
    chk("rst_state1", 64'({rr[1], sv[1], o1}), 64'({1'b1, 1'b0, 8'd0}));
    chk("rst_state2", 64'({rr[2], sv[2], o2}), 64'({1'b1, 1'b0, 8'd0}));
    reset = 1'b1;
    @(negedge clk);

    issue(2'b00, 32'd3, 32'd4);
    collect("mul_3x4", 32'd12, 4, 0, 0);
    issue(2'b00, 32'hDEAD_BEEF, 32'd0);
    collect("mul_b0", 32'd0, 2, 0, 0);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect("mul_ones", 32'd1, 34, 0, 0);
    issue(2'b01, 32'hFFFF_FFFE, 32'd3);
    collect("mulh_m2x3", 32'hFFFF_FFFF, 4, 0, 0);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000);
    collect("mulh_min", 32'h4000_0000, 7, 0, 0);
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect("mulhu_ones", 32'hFFFF_FFFE, 34, 0, 0);
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect("mulhsu_ones", 32'hFFFF_FFFF, 34, 0, 0);

    // Backpressure with a new request already waiting on the input.
    issue(2'b00, 32'd5, 32'd9);
    w = 0;
    while (sv[0] !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("bp_lat", 64'(cyc - acc_cyc + 1), 64'd4);
    chk("bp_msg", 64'(o0), 64'd45);
    drive(1'b1, 2'b00, 32'd11, 32'd13);
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold", {sv[0], rr[0], o0}, {1'b1, 1'b0, 32'd45});
    end
    sr[0] = 1'b1;
    @(negedge clk);
    sr[0] = 1'b0;
    chk("bp_after_hs", 64'({rr[0], sv[0]}), 64'b10);
    @(negedge clk);
    acc_cyc = cyc;
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    chk("bp_accepted", 64'(rr[0]), 64'd0);
    collect("bp_next", 32'd143, 5, 0, 0);

    // Abort a long transaction with an asynchronous reset pulse.
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_calc", 64'({rr[0], sv[0]}), 64'b10);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale", 64'({rr[0], sv[0]}), 64'b10);
    end
    issue(2'b00, 32'd7, 32'd6);
    collect("mul_7x6", 32'd42, 5, 0, 0);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      ntx = (s == 0) ? 400 : 300;
      for (int t = 0; t < ntx; t++) begin
        m = 2'($urandom_range(0, 3));
        a = pick(nb_of[s]);
        b = pick(nb_of[s]);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(m, a, b);
        collect("rand", ref_mul(nb_of[s], m, a, b),
                ref_iters(nb_of[s], sk_of[s], m, b) + 2,
                int'($urandom_range(0, 3)), 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imul_var_lat_param.md
# imul_var_lat_param

Parametrised variable-latency iterative integer multiplier with a full val/rdy request/response interface. It replaces the fixed-latency shift-add datapath/control pair with one self-contained block. The block adds operand-width generalisation, four RISC-V-style multiply modes (low, high signed, high unsigned, high signed-unsigned) and zero-run skipping, so latency tracks the number of set bits in the multiplier operand. It sits between the processor's request queue and its writeback stage, as the long-latency multiply unit.

## Interface

Parameters:

- NBITS, 32, operand and result width; must be ≥ 4.
- SKIP_MAX, 8, largest shift applied in one iteration; 1 ≤ SKIP_MAX ≤ NBITS-1.

Ports:

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting it (low) clears all state immediately; deassertion is synchronous to clk.
- req_val  input  1  request valid.
- req_rdy  output  1  request ready.
- req_msg  input  2*NBITS+2  request message, {mode[1:0], a[NBITS-1:0], b[NBITS-1:0]}.
  - mode 00: MUL, low half of the product.
  - mode 01: MULH, high half, signed×signed.
  - mode 10: MULHU, high half, unsigned×unsigned.
  - mode 11: MULHSU, high half, signed a × unsigned b.
- resp_val  output  1  response valid.
- resp_rdy  input  1  response ready.
- resp_msg  output  NBITS  result.

## Operation

- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- Registers:
  - a_reg, 2*NBITS wide.
  - b_reg, NBITS wide.
  - acc, 2*NBITS wide.
  - neg, 1 bit.
  - mode_reg, 2 bits.
- IDLE:
  - req_rdy=1.
  - On req_val && req_rdy, load the operands and go to CALC:
    - a_reg = |a| zero-extended; a is treated as signed in modes 01 and 11.
    - b_reg = |b|; b is treated as signed in mode 01 only.
    - neg = XOR of the signs of the signed-treated operands.
    - acc = 0.
    - mode_reg = mode.
  - The magnitude of the most-negative value, 2^(NBITS-1), fits unsigned in NBITS bits. No overflow special case is needed.
- CALC, one cycle per iteration:
  - If b_reg == 0, go to DONE. No other update that cycle.
  - Otherwise:
    - If b_reg[0] == 1, then acc += a_reg (mod 2^(2*NBITS)).
    - Shift a_reg left by k and b_reg right by k, both logical.
    - k is the index of the lowest set bit of b_reg in positions 1..SKIP_MAX. If none of those bits is set, k = SKIP_MAX.
- DONE:
  - resp_val=1.
  - p = neg ? -acc : acc, computed in 2*NBITS bits, two's complement.
  - resp_msg = p[NBITS-1:0] when mode_reg == 00, else p[2*NBITS-1:NBITS].
  - On resp_rdy, go to IDLE.
- Outputs outside DONE:
  - resp_val=0.
  - resp_msg is held at the DONE value and is a don't-care for checking.
- req_rdy=0 in CALC and DONE. Only one transaction is in flight; there is no request/response overlap.
- Reset values:
  - state=IDLE; req_rdy=1; resp_val=0.
  - a_reg, b_reg, acc, neg, mode_reg all 0; resp_msg=0.
- Reset asserted in any state aborts the transaction silently. No response is produced and the next request after deassertion is handled normally.

## Timing

- Request accepted at edge T:
  - CALC occupies cycles T+1 … T+n+1, where n is the number of iterations (shifts) needed to drain b_reg.
  - resp_val rises in cycle T+n+2.
- Limit cases of n:
  - b = 0 gives n = 0; resp_val is seen 2 cycles after acceptance.
  - The unsigned all-ones b gives n = NBITS: 1 CALC cycle per bit plus the final zero-check.
  - Upper bound of the request-to-response latency: NBITS+2 cycles.
- n is computed on the magnitude |b|, not on the raw b.
- An iteration may shift past the top of b_reg; b_reg then becomes 0 and the next CALC cycle exits.
- DONE holds resp_val and resp_msg stable indefinitely while resp_rdy=0.
- Back-to-back:
  - The response handshake in DONE at edge U returns the FSM to IDLE.
  - A new request can be accepted at edge U+1 at the earliest.
- req_val or req_msg changing while req_rdy=0 has no effect.

## Test plan

- MUL, a=3, b=4 → resp_msg=12. With b=4=0b100: iteration 1 shifts k=2, iteration 2 adds and shifts k=SKIP_MAX. resp_val appears 4 cycles after acceptance.
- MUL, a=0xDEADBEEF, b=0 → resp_msg=0, resp_val appears 2 cycles after acceptance. Also MUL, a=0xFFFFFFFF, b=0xFFFFFFFF → resp_msg=0x00000001, latency 34 cycles.
- Mode coverage, NBITS=32:
  - MULH, a=0xFFFFFFFE (-2), b=3 → 0xFFFFFFFF.
  - MULH, a=0x80000000, b=0x80000000 → 0x40000000.
  - MULHU, a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU, a=0xFFFFFFFF (-1), b=0xFFFFFFFF → 0xFFFFFFFF.
- Backpressure:
  - Hold resp_rdy=0 for 10 cycles in DONE → resp_val and resp_msg stay stable and req_rdy stays 0.
  - A new req_val held during that window is accepted only one cycle after the response handshake.
- Reset mid-CALC: pull reset low for one cycle → req_rdy=1 and resp_val=0 immediately. Then MUL, a=7, b=6 → 42 with no stale response.
- Random: 1000 transactions, all modes, random val/rdy stalls, NBITS ∈ {8, 32}, SKIP_MAX ∈ {1, 4, 8} → every response matches the reference model and latency equals n+2.
